// File: rtl/pipeline_pkg.sv
// Shared types for the 8-bit pipeline back end.
// Carries the MEM/WB bundle layout and the memory handshake states.
package pipeline_pkg;

  localparam int DW = 8;
  localparam int RW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] ra;
    logic          reg_en;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  function automatic logic is_mem_op(
    input logic wr_en,
    input logic wb_sel
  );
    return wr_en | wb_sel;
  endfunction

endpackage

// File: rtl/pipeline_mem_wb_reg.sv
// MEM/WB pipeline register with synchronous reset and bubble insert.
// Also driven by the hazard unit's flush path.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_bubble,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= MEM_WB_BUBBLE;
    end else if (i_bubble) begin
      r_q <= MEM_WB_BUBBLE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_mem.sv
// Memory stage: data-memory req/ack handshake, upstream stall,
// bounded wait with sticky bus error, and the MEM/WB register.
module pipeline_mem
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ALU,
  input  logic [RW-1:0] ra,
  input  logic [DW-1:0] ea,
  input  logic          mem_wr_en,
  input  logic          mem_imm_sel,
  input  logic          wb_wb_sel,
  input  logic          wb_reg_en,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall_out,
  output logic [DW-1:0] wb_data_out,
  output logic [RW-1:0] ra_out,
  output logic          wb_reg_en_out,
  output logic          bus_err_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e r_state;
  logic [7:0] r_cnt;
  logic       r_bus_err;

  logic          w_mem_op;
  logic          w_in_wait;
  logic          w_timeout;
  logic          w_done;
  logic          w_load;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] w_wb_data;
  mem_wb_t       w_mem_wb_d;
  mem_wb_t       w_mem_wb_q;

  assign w_mem_op  = is_mem_op(mem_wr_en, wb_wb_sel);
  assign w_in_wait = (r_state == WAIT);
  assign w_timeout = w_in_wait & (r_cnt == CNT_LAST);
  assign w_done    = dmem_ack | w_timeout;

  assign dmem_req   = ~rst & (w_in_wait | w_mem_op);
  assign dmem_we    = mem_wr_en;
  assign dmem_addr  = mem_imm_sel ? ea : ALU;
  assign dmem_wdata = mem_imm_sel ? ALU : ea;
  assign stall_out  = dmem_req & ~w_done;

  // A timed-out load returns zero rather than whatever is on the bus.
  assign w_load    = wb_wb_sel & ~mem_wr_en;
  assign w_rdata   = dmem_ack ? dmem_rdata : '0;
  assign w_wb_data = w_load ? w_rdata : ALU;

  assign w_mem_wb_d = '{
    data:   w_wb_data,
    ra:     ra,
    reg_en: wb_reg_en
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_mem_op & ~dmem_ack) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (w_timeout & ~dmem_ack) begin
              r_bus_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (stall_out),
    .i_d      (w_mem_wb_d),
    .o_q      (w_mem_wb_q)
  );

  assign wb_data_out   = w_mem_wb_q.data;
  assign ra_out        = w_mem_wb_q.ra;
  assign wb_reg_en_out = w_mem_wb_q.reg_en;
  assign bus_err_out   = r_bus_err;

endmodule

// File: tb/tb_pipeline_mem.sv
// Randomized bench for pipeline_mem against an instruction-level model:
// each op's stall length, bus fields and write-back result come from the rules.
module tb_pipeline_mem;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ALU, ea, dmem_rdata;
  logic [1:0] ra;
  logic       mem_wr_en, mem_imm_sel, wb_wb_sel, wb_reg_en, dmem_ack;
  logic       dmem_req, dmem_we, stall_out;
  logic [7:0] dmem_addr, dmem_wdata, wb_data_out;
  logic [1:0] ra_out;
  logic       wb_reg_en_out, bus_err_out;

  int   total = 0;
  int   bad   = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  pipeline_mem #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALU           (ALU),
    .ra            (ra),
    .ea            (ea),
    .mem_wr_en     (mem_wr_en),
    .mem_imm_sel   (mem_imm_sel),
    .wb_wb_sel     (wb_wb_sel),
    .wb_reg_en     (wb_reg_en),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .stall_out     (stall_out),
    .wb_data_out   (wb_data_out),
    .ra_out        (ra_out),
    .wb_reg_en_out (wb_reg_en_out),
    .bus_err_out   (bus_err_out)
  );

  // One instruction held at the stage input until the model says it retires.
  // d = cycle (0 = first request cycle) on which ack arrives; -1 = never.
  task automatic run_op(
    input string      tag,
    input logic [7:0] alu,
    input logic [1:0] rd,
    input logic [7:0] eav,
    input logic       wr,
    input logic       imm,
    input logic       wbs,
    input logic       ren,
    input int         d,
    input logic [7:0] rdv
  );
    logic       op, acked;
    int         ns;
    logic [7:0] ed;
    logic [16:0] bus_exp, bus_got;
    op    = wr | wbs;
    acked = op && d >= 0 && d <= TO;
    ns    = !op ? 0 : (acked ? d : TO);
    ALU = alu; ra = rd; ea = eav;
    mem_wr_en = wr; mem_imm_sel = imm; wb_wb_sel = wbs; wb_reg_en = ren;
    bus_exp = {(imm ? eav : alu), wr, (imm ? alu : eav)};
    for (int k = 0; k <= ns; k++) begin
      dmem_ack   = op ? (k == d) : 1'($urandom);
      dmem_rdata = (op && k == d) ? rdv : 8'($urandom);
      @(negedge clk);
      total++;
      if (dmem_req !== op) begin
        bad++;
        $display("FAIL %s req k=%0d: got %b want %b", tag, k, dmem_req, op);
      end
      total++;
      if (stall_out !== (k < ns)) begin
        bad++;
        $display("FAIL %s stall k=%0d: got %b want %b", tag, k, stall_out, k < ns);
      end
      if (op) begin
        bus_got = {dmem_addr, dmem_we, dmem_wdata};
        total++;
        if (bus_got !== bus_exp) begin
          bad++;
          $display("FAIL %s bus k=%0d: got %h want %h", tag, k, bus_got, bus_exp);
        end
      end
      if (k > 0) begin
        total++;
        if (wb_reg_en_out !== 1'b0) begin
          bad++;
          $display("FAIL %s bubble k=%0d: got %b want 0", tag, k, wb_reg_en_out);
        end
      end
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
    ed = (wbs && !wr) ? (acked ? rdv : 8'h00) : alu;
    if (op && !acked) exp_err = 1'b1;
    total++;
    if ({wb_data_out, ra_out, wb_reg_en_out} !== {ed, rd, ren}) begin
      bad++;
      $display("FAIL %s memwb: got %h/%0d/%b want %h/%0d/%b", tag,
               wb_data_out, ra_out, wb_reg_en_out, ed, rd, ren);
    end
    total++;
    if (bus_err_out !== exp_err) begin
      bad++;
      $display("FAIL %s bus_err: got %b want %b", tag, bus_err_out, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ALU = 8'($urandom); ea = 8'($urandom); ra = 2'($urandom);
    mem_wr_en = 1'b1; wb_wb_sel = 1'b1; wb_reg_en = 1'b1;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({dmem_req, stall_out} !== 2'b00) begin
      bad++;
      $display("FAIL reset_req_stall: got %b want 00", {dmem_req, stall_out});
    end
    @(posedge clk);
    #1;
    total++;
    if ({wb_data_out, ra_out, wb_reg_en_out, bus_err_out} !== 12'h0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 000",
               {wb_data_out, ra_out, wb_reg_en_out, bus_err_out});
    end
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic test_alu_pass();
    run_op("alu", 8'h3C, 2'd2, 8'($urandom), 1'b0, 1'($urandom),
           1'b0, 1'b1, -1, 8'h00);
  endtask

  task automatic test_load_same_cycle();
    run_op("ld_now", 8'($urandom), 2'd1, 8'h80, 1'b0, 1'b1,
           1'b1, 1'b1, 0, 8'hA5);
  endtask

  task automatic test_store_wait();
    run_op("st_wait", 8'h10, 2'd3, 8'h77, 1'b1, 1'b0,
           1'b0, 1'b0, 3, 8'hEE);
  endtask

  task automatic test_timeout();
    run_op("ld_to", 8'h44, 2'd1, 8'h90, 1'b0, 1'b1,
           1'b1, 1'b1, -1, 8'h00);
    run_op("after_to_alu", 8'h21, 2'd0, 8'h00, 1'b0, 1'b0,
           1'b0, 1'b1, -1, 8'h00);
    run_op("after_to_ld", 8'h02, 2'd3, 8'h00, 1'b0, 1'b0,
           1'b1, 1'b1, 2, 8'h6B);
  endtask

  task automatic test_rst_mid_wait();
    ALU = 8'h33; ra = 2'd2; ea = 8'h40;
    mem_wr_en = 1'b0; mem_imm_sel = 1'b1; wb_wb_sel = 1'b1; wb_reg_en = 1'b1;
    dmem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({dmem_req, stall_out} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_req_stall: got %b want 00", {dmem_req, stall_out});
    end
    @(posedge clk);
    #1;
    total++;
    if ({wb_data_out, ra_out, wb_reg_en_out, bus_err_out} !== 12'h0) begin
      bad++;
      $display("FAIL midrst_outs: got %h want 000",
               {wb_data_out, ra_out, wb_reg_en_out, bus_err_out});
    end
    rst = 1'b0;
    exp_err = 1'b0;
    run_op("post_rst_ld", 8'h00, 2'd1, 8'h40, 1'b0, 1'b1,
           1'b1, 1'b1, 1, 8'hC3);
  endtask

  task automatic test_store_priority();
    run_op("st_prio", 8'h5A, 2'd2, 8'h12, 1'b1, 1'b0,
           1'b1, 1'b1, 0, 8'h99);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 60; i++) begin
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 18));
      run_op("rand", 8'($urandom), 2'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             d, 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    ALU = '0; ra = '0; ea = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    mem_wr_en = 1'b0; mem_imm_sel = 1'b0; wb_wb_sel = 1'b0; wb_reg_en = 1'b0;
    test_reset();
    test_alu_pass();
    test_load_same_cycle();
    test_store_wait();
    test_timeout();
    test_rst_mid_wait();
    test_store_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_mem.md
Name: pipeline_mem

Overview:
- Memory stage of the 8-bit pipeline; consumes the EX/MEM register outputs (ALU result, destination register, effective address, MEM/WB control bits).
- Performs the data-memory load/store over a req/ack handshake and stalls upstream while the access is outstanding.
- Holds the MEM/WB pipeline register feeding the register-file write port.
- Bounds memory waits with a timeout that raises a sticky error.

Parameters:
TIMEOUT, 15, maximum wait cycles in WAIT before forced completion (1..255; counter width 8)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ALU  input  8  ALU result from EX/MEM register
ra  input  2  destination register index
ea  input  8  effective address / register-indirect operand
mem_wr_en  input  1  store request
mem_imm_sel  input  1  1: addr=ea, wdata=ALU; 0: addr=ALU, wdata=ea
wb_wb_sel  input  1  1: write back load data; 0: write back ALU
wb_reg_en  input  1  register-file write enable
dmem_req  output  1  memory request (combinational)
dmem_we  output  1  memory write strobe, valid with dmem_req
dmem_addr  output  8  memory address
dmem_wdata  output  8  store data
dmem_rdata  input  8  load data, valid with dmem_ack
dmem_ack  input  1  access complete (may be same cycle as req)
stall_out  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
wb_data_out  output  8  MEM/WB write-back data (reg)
ra_out  output  2  MEM/WB destination index (reg)
wb_reg_en_out  output  1  MEM/WB write enable (reg)
bus_err_out  output  1  sticky timeout flag (reg)

Behaviour:
- Reset values: wb_data_out=0, ra_out=0, wb_reg_en_out=0, bus_err_out=0, FSM=IDLE, wait counter=0. While rst=1: dmem_req=0, stall_out=0, regardless of inputs.
- Memory op (mem_op) = mem_wr_en | wb_wb_sel. Store takes priority: if both are set, dmem_we=1 and wb_data = ALU.
- dmem_addr = mem_imm_sel ? ea : ALU; dmem_wdata = mem_imm_sel ? ALU : ea; dmem_we = mem_wr_en.
- done = dmem_ack | (state==WAIT & cnt==TIMEOUT-1).
- FSM IDLE:
  - mem_op=0: dmem_req=0, stall_out=0; MEM/WB loads {ALU, ra, wb_reg_en} next edge (1-cycle latency).
  - mem_op=1: dmem_req=1.
    - ack same cycle: no stall; MEM/WB loads {wb_data, ra, wb_reg_en}; stay IDLE.
    - no ack: stall_out=1; MEM/WB loads bubble (wb_reg_en_out=0, other fields 0); go to WAIT, cnt=0.
- FSM WAIT: dmem_req=1, inputs held stable by the upstream stall; stall_out=~done.
  - Not done: cnt++, MEM/WB loads bubble.
  - Done via ack: MEM/WB loads result, go IDLE, cnt=0.
  - Done via timeout (no ack): load data 8'h00, wb_reg_en_out=wb_reg_en, set bus_err_out=1, go IDLE. Total stall = TIMEOUT cycles.
- Write-back data: wb_data = (wb_wb_sel & ~mem_wr_en) ? dmem_rdata (8'h00 on timeout) : ALU.
- bus_err_out is cleared only by rst.
- A late ack arriving in IDLE with mem_op=0 is ignored.
- Exactly one request per instruction: after completion, stall drops and upstream advances on the same edge, so no re-issue.
- rst mid-WAIT: next edge FSM=IDLE, all registered outputs 0, access abandoned; dmem_req drops in the same cycle rst is asserted.

Decomposition:
- Shared package pipeline_pkg:
  - FSM state enum {IDLE, WAIT}
  - data width 8, register-index width 2
  - bubble constant for the MEM/WB bundle
- One sub-module: mem_wb_reg (MEM/WB register with reset and bubble-insert input), reused by the hazard unit's flush path.
- Handshake FSM and timeout counter stay in pipeline_mem.

Test Plan:
- ALU=8'h3C, ra=2, wb_reg_en=1, no mem op -> next edge wb_data_out=3C, ra_out=2, wb_reg_en_out=1, dmem_req never 1, stall_out=0.
- Load, mem_imm_sel=1, ea=8'h80, ack same cycle with rdata=8'hA5 -> dmem_addr=80, dmem_we=0, no stall, next edge wb_data_out=A5.
- Store, mem_imm_sel=0, ALU=8'h10, ea=8'h77, ack after 3 cycles -> dmem_addr=10, wdata=77, we=1; stall_out high 3 cycles; wb_reg_en_out=0 during those cycles; one request only.
- Load, ack never, TIMEOUT=15 -> stall_out high 15 cycles; then wb_data_out=00, bus_err_out=1; bus_err_out persists through later ops until rst.
- rst asserted in 2nd WAIT cycle -> same cycle dmem_req=0, stall_out=0; next edge all outputs 0, FSM IDLE; following load completes normally.
- mem_wr_en=1 and wb_wb_sel=1, ALU=8'h5A, ack immediate -> dmem_we=1, wb_data_out=5A.
